// File: rtl/ntt_result_reader.sv
// Drains final NTT coefficients from a ping-pong RAM bank pair as a valid/ready stream.
// Optional macro READER_BITREV_EN: issue reads at bit-reversed addresses (needs DEPTH == 2**ADDR_W).
module ntt_result_reader #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_rd,
  input  logic              bank_sel,
  output logic              ram0_enb,
  output logic              ram1_enb,
  output logic              ram2_enb,
  output logic              ram3_enb,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] ram0_doutb,
  input  logic [DATA_W-1:0] ram1_doutb,
  input  logic [DATA_W-1:0] ram2_doutb,
  input  logic [DATA_W-1:0] ram3_doutb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data0,
  output logic [DATA_W-1:0] m_data1,
  output logic              m_last,
  output logic              busy,
  output logic              rd_done
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  localparam logic [ADDR_W:0] MLast = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] MOne  = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W:0]   m_q, m_d;
  logic              inflight_q, inflight_last_q;
  logic              rd_done_q, rd_done_d;

  // Two-entry output buffer: head feeds the stream, tail holds the overflow entry.
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] head0_q, head0_d, head1_q, head1_d;
  logic [DATA_W-1:0] tail0_q, tail0_d, tail1_q, tail1_d;
  logic              head_last_q, head_last_d, tail_last_q, tail_last_d;

  logic              pop;
  logic              issue;
  logic [2:0]        credit;
  logic [DATA_W-1:0] cap0, cap1;

  assign pop = (occ_q != 2'd0) && m_ready;

  // Count the entry leaving this cycle so a full-rate stream keeps one read per cycle.
  assign credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = (state_q == StRead) && (credit < 3'd2);

  assign cap0 = sel_q ? ram2_doutb : ram0_doutb;
  assign cap1 = sel_q ? ram3_doutb : ram1_doutb;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    m_d       = m_q;
    rd_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_rd) begin
          state_d = StRead;
          sel_d   = bank_sel;
          m_d     = '0;
        end
      end
      StRead: begin
        if (issue) begin
          m_d = m_q + MOne;
          if (m_q == MLast) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && head_last_q) begin
          state_d   = StIdle;
          rd_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    occ_d       = occ_q;
    head0_d     = head0_q;
    head1_d     = head1_q;
    head_last_d = head_last_q;
    tail0_d     = tail0_q;
    tail1_d     = tail1_q;
    tail_last_d = tail_last_q;
    case ({pop, inflight_q})
      2'b01: begin
        if (occ_q == 2'd0) begin
          head0_d     = cap0;
          head1_d     = cap1;
          head_last_d = inflight_last_q;
        end else begin
          tail0_d     = cap0;
          tail1_d     = cap1;
          tail_last_d = inflight_last_q;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b10: begin
        head0_d     = tail0_q;
        head1_d     = tail1_q;
        head_last_d = tail_last_q;
        occ_d       = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head0_d     = cap0;
          head1_d     = cap1;
          head_last_d = inflight_last_q;
        end else begin
          head0_d     = tail0_q;
          head1_d     = tail1_q;
          head_last_d = tail_last_q;
          tail0_d     = cap0;
          tail1_d     = cap1;
          tail_last_d = inflight_last_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      sel_q           <= 1'b0;
      m_q             <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_done_q       <= 1'b0;
      occ_q           <= 2'd0;
      head0_q         <= '0;
      head1_q         <= '0;
      head_last_q     <= 1'b0;
      tail0_q         <= '0;
      tail1_q         <= '0;
      tail_last_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      m_q             <= m_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (m_q == MLast);
      rd_done_q       <= rd_done_d;
      occ_q           <= occ_d;
      head0_q         <= head0_d;
      head1_q         <= head1_d;
      head_last_q     <= head_last_d;
      tail0_q         <= tail0_d;
      tail1_q         <= tail1_d;
      tail_last_q     <= tail_last_d;
    end
  end

`ifdef READER_BITREV_EN
  always_comb begin
    r_addr = '0;
    for (int i = 0; i < int'(ADDR_W); i++) begin
      r_addr[i] = m_q[ADDR_W-1-i];
    end
  end
`else
  assign r_addr = m_q[ADDR_W-1:0];
`endif

  assign ram0_enb = issue && !sel_q;
  assign ram1_enb = issue && !sel_q;
  assign ram2_enb = issue && sel_q;
  assign ram3_enb = issue && sel_q;

  assign m_valid = (occ_q != 2'd0);
  assign m_data0 = head0_q;
  assign m_data1 = head1_q;
  assign m_last  = head_last_q;
  assign busy    = (state_q != StIdle);
  assign rd_done = rd_done_q;

  // A capture into a full buffer with no pop would lose a beat.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(inflight_q && (occ_q == 2'd2) && !pop));

endmodule

// File: tb/tb_ntt_result_reader.sv
// Table-driven bench for ntt_result_reader: each record is one drain scenario with expected totals.
module tb_ntt_result_reader;
  localparam int AW = 7;
  localparam int DP = 128;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_rd = 1'b0;
  logic          bank_sel = 1'b0;
  logic          m_ready = 1'b0;
  logic          ram0_enb, ram1_enb, ram2_enb, ram3_enb;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] ram0_doutb, ram1_doutb, ram2_doutb, ram3_doutb;
  logic          m_valid, m_last, busy, rd_done;
  logic [DW-1:0] m_data0, m_data1;

  logic [DW-1:0] mem0 [DP];
  logic [DW-1:0] mem1 [DP];
  logic [DW-1:0] mem2 [DP];
  logic [DW-1:0] mem3 [DP];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit sel;
    int mode;          // 0 ready high, 1 random, 2 random then 20-cycle stall
    int restart_beat;  // -1: none
    int reset_beat;    // -1: none
    int exp_beats;
    int exp_dones;
    int exp_done_cycle; // -1: not checked
    int exp_first_valid;
  } vec_t;

  vec_t vecs [6];

  ntt_result_reader #(.ADDR_W(AW), .DEPTH(DP), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_rd(start_rd), .bank_sel(bank_sel),
    .ram0_enb(ram0_enb), .ram1_enb(ram1_enb), .ram2_enb(ram2_enb), .ram3_enb(ram3_enb),
    .r_addr(r_addr),
    .ram0_doutb(ram0_doutb), .ram1_doutb(ram1_doutb),
    .ram2_doutb(ram2_doutb), .ram3_doutb(ram3_doutb),
    .m_valid(m_valid), .m_ready(m_ready), .m_data0(m_data0), .m_data1(m_data1),
    .m_last(m_last), .busy(busy), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  // Port-B RAM models with one cycle of read latency.
  always @(posedge clk) begin
    if (ram0_enb) ram0_doutb <= mem0[r_addr];
    if (ram1_enb) ram1_doutb <= mem1[r_addr];
    if (ram2_enb) ram2_doutb <= mem2[r_addr];
    if (ram3_enb) ram3_doutb <= mem3[r_addr];
  end

  function automatic int exp_addr(input int n);
`ifdef READER_BITREV_EN
    int r;
    r = 0;
    for (int i = 0; i < AW; i++) if (n[i]) r = r | (1 << (AW - 1 - i));
    return r;
`else
    return n;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_enb"}, {ram0_enb, ram1_enb, ram2_enb, ram3_enb}, 0);
    chk({tag, "_addr"}, r_addr, 0);
    chk({tag, "_data"}, {m_data0, m_data1}, 0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, rd_done, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int cycle, issued, beats, dones, done_cycle, first_valid, post, stall_left, a;
    bit restarted, prev_stall, finished;
    logic [DW-1:0] pd0, pd1;
    logic pl;
    cycle = 0; issued = 0; beats = 0; dones = 0; done_cycle = -1; first_valid = -1;
    post = 0; stall_left = 20; restarted = 0; prev_stall = 0; finished = 0;
    pd0 = '0; pd1 = '0; pl = 1'b0;
    @(negedge clk);
    start_rd = 1'b1;
    bank_sel = v.sel;
    while (!finished) begin
      @(negedge clk);
      cycle++;
      start_rd = 1'b0;
      bank_sel = v.sel;
      if (v.reset_beat >= 0 && beats == v.reset_beat) begin
        rst_n = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_quiet("after_reset");
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          #1;
          chk("no_done_after_reset", rd_done, 0);
        end
        chk("beats_before_reset", beats, v.exp_beats);
        chk("first_valid", first_valid, v.exp_first_valid);
        return;
      end
      case (v.mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        default: begin
          if (beats >= 50 && stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
          end else if (beats >= 50) m_ready = 1'b1;
          else m_ready = 1'($urandom_range(0, 1));
        end
      endcase
      if (v.restart_beat >= 0 && beats == v.restart_beat && !restarted) begin
        start_rd = 1'b1;
        bank_sel = ~v.sel;
        restarted = 1;
      end
      #1;
      if (cycle == 1) chk("busy_after_start", busy, 1);
      if (m_valid && first_valid < 0) first_valid = cycle;
      if (v.sel) chk("unselected_enb", {ram0_enb, ram1_enb}, 0);
      else chk("unselected_enb", {ram2_enb, ram3_enb}, 0);
      if (ram0_enb || ram1_enb || ram2_enb || ram3_enb) begin
        chk("enb_pair", v.sel ? {ram2_enb, ram3_enb} : {ram0_enb, ram1_enb}, 2'b11);
        chk("r_addr", r_addr, exp_addr(issued));
        issued++;
      end
      if (prev_stall && m_valid) chk("stall_stable", {m_data0, m_data1, m_last}, {pd0, pd1, pl});
      if (m_valid && m_ready) begin
        a = exp_addr(beats);
        chk("data0", m_data0, v.sel ? mem2[a] : mem0[a]);
        chk("data1", m_data1, v.sel ? mem3[a] : mem1[a]);
        chk("last", m_last, beats == DP - 1);
        beats++;
      end
      chk("outstanding_over_2", (issued - beats) > 2, 0);
      prev_stall = m_valid && !m_ready;
      pd0 = m_data0; pd1 = m_data1; pl = m_last;
      if (rd_done) begin
        dones++;
        if (done_cycle < 0) begin
          done_cycle = cycle;
          chk("busy_at_done", busy, 0);
        end
      end
      if (done_cycle >= 0) post++;
      if (post > 5) finished = 1;
      if (cycle > 3000) begin
        n_cmp++;
        n_err++;
        $display("FAIL timeout: drain did not complete within 3000 cycles");
        finished = 1;
      end
    end
    m_ready = 1'b0;
    chk("beats", beats, v.exp_beats);
    chk("reads_issued", issued, DP);
    chk("rd_done_count", dones, v.exp_dones);
    chk("first_valid", first_valid, v.exp_first_valid);
    if (v.exp_done_cycle >= 0) chk("done_cycle", done_cycle, v.exp_done_cycle);
  endtask

  initial begin
    for (int k = 0; k < DP; k++) begin
      mem0[k] = DW'(2 * k);
      mem1[k] = DW'(2 * k + 1);
      mem2[k] = DW'(16'hA000 + 3 * k);
      mem3[k] = DW'(16'h5000 ^ (7 * k));
    end
    vecs[0] = '{sel: 0, mode: 0, restart_beat: -1, reset_beat: -1, exp_beats: DP,
                exp_dones: 1, exp_done_cycle: DP + 3, exp_first_valid: 3};
    vecs[1] = '{sel: 1, mode: 0, restart_beat: -1, reset_beat: -1, exp_beats: DP,
                exp_dones: 1, exp_done_cycle: DP + 3, exp_first_valid: 3};
    vecs[2] = '{sel: 0, mode: 2, restart_beat: -1, reset_beat: -1, exp_beats: DP,
                exp_dones: 1, exp_done_cycle: -1, exp_first_valid: 3};
    vecs[3] = '{sel: 1, mode: 1, restart_beat: 40, reset_beat: -1, exp_beats: DP,
                exp_dones: 1, exp_done_cycle: -1, exp_first_valid: 3};
    vecs[4] = '{sel: 0, mode: 0, restart_beat: -1, reset_beat: 60, exp_beats: 60,
                exp_dones: 0, exp_done_cycle: -1, exp_first_valid: 3};
    vecs[5] = '{sel: 0, mode: 0, restart_beat: -1, reset_beat: -1, exp_beats: DP,
                exp_dones: 1, exp_done_cycle: DP + 3, exp_first_valid: 3};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      repeat (3) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
